// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_MULTU= 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SRL  = 4'b1110;
  localparam logic [3:0] OP_SLL  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // mult/multu/div/divu run in the iterative unit
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per step, with sign correction applied combinationally.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load         latch op and operands, clear partial result
//   step         perform one iteration
//   op           operation code (mult/multu/div/divu)
//   a, b         operands (a = multiplicand/dividend, b = multiplier/divisor)
//   hi_c, lo_c   sign-corrected HI/LO of the current contents (valid after WIDTH steps)
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0]   hi_q, lo_q, dvsr_q, a_raw_q;
  logic           mul_q, neg_x_q, a_neg_q;

  logic           sgn_c, a_neg_c, b_neg_c;
  logic [W-1:0]   a_mag_c, b_mag_c;
  logic [W:0]     add_c, shl_c, sub_c;
  logic           ge_c;
  logic [2*W-1:0] prod_c, prod_fix_c;

  // Operand magnitudes for the signed variants
  always_comb begin
    sgn_c   = (op == OP_MULT) || (op == OP_DIV);
    a_neg_c = sgn_c & a[W-1];
    b_neg_c = sgn_c & b[W-1];
    a_mag_c = a_neg_c ? W'(-a) : a;
    b_mag_c = b_neg_c ? W'(-b) : b;
  end

  // One iteration: add-and-shift-right for multiply, shift-and-subtract for divide
  always_comb begin
    add_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q} : '0);
    shl_c = {hi_q, lo_q[W-1]};
    ge_c  = shl_c >= {1'b0, dvsr_q};
    sub_c = shl_c - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      dvsr_q  <= '0;
      a_raw_q <= '0;
      mul_q   <= 1'b0;
      neg_x_q <= 1'b0;
      a_neg_q <= 1'b0;
    end else if (load) begin
      hi_q    <= '0;
      lo_q    <= a_mag_c;
      dvsr_q  <= b_mag_c;
      a_raw_q <= a;
      mul_q   <= (op == OP_MULT) || (op == OP_MULTU);
      neg_x_q <= a_neg_c ^ b_neg_c;
      a_neg_q <= a_neg_c;
    end else if (step) begin
      if (mul_q) begin
        hi_q <= add_c[W:1];
        lo_q <= {add_c[0], lo_q[W-1:1]};
      end else if (ge_c) begin
        hi_q <= W'(sub_c);
        lo_q <= {lo_q[W-2:0], 1'b1};
      end else begin
        hi_q <= shl_c[W-1:0];
        lo_q <= {lo_q[W-2:0], 1'b0};
      end
    end
  end

  // Sign fix; a zero divisor reports all-ones quotient and the raw dividend
  always_comb begin
    prod_c     = {hi_q, lo_q};
    prod_fix_c = neg_x_q ? (2*W)'(-prod_c) : prod_c;
    if (mul_q) begin
      hi_c = prod_fix_c[2*W-1:W];
      lo_c = prod_fix_c[W-1:0];
    end else if (dvsr_q == '0) begin
      hi_c = a_raw_q;
      lo_c = '1;
    end else begin
      hi_c = a_neg_q ? W'(-hi_q) : hi_q;
      lo_c = neg_x_q ? W'(-lo_q) : lo_q;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/compare/shift ops plus an
// iterative mult/div unit writing HI/LO.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               issue request (ignored while busy)
//   aluControl          op select
//   in1, in2, shamt     operands and shift amount
//   out                 registered result
//   zeroFlag, overflow  registered result flags
//   busy                multi-cycle op in progress
//   done                one-cycle pulse for a new result
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             zeroFlag,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W = WIDTH;

  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   out_d;
  logic           zf_d, ovf_d, busy_d, done_d;

  logic [W-1:0]   sum_c, diff_c, sc_res_c;
  logic           sc_ovf_c;
  logic           mdu_load_c, mdu_step_c;
  logic [W-1:0]   mdu_hi_c, mdu_lo_c;

  mdu_iter #(.WIDTH(W)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .load  (mdu_load_c),
    .step  (mdu_step_c),
    .op    (aluControl),
    .a     (in1),
    .b     (in2),
    .hi_c  (mdu_hi_c),
    .lo_c  (mdu_lo_c)
  );

  // Single-cycle result and signed overflow
  always_comb begin
    sum_c    = in1 + in2;
    diff_c   = in1 - in2;
    sc_res_c = '0;
    sc_ovf_c = 1'b0;
    case (aluControl)
      OP_AND:  sc_res_c = in1 & in2;
      OP_OR:   sc_res_c = in1 | in2;
      OP_XOR:  sc_res_c = in1 ^ in2;
      OP_ADD: begin
        sc_res_c = sum_c;
        sc_ovf_c = (in1[W-1] == in2[W-1]) && (sum_c[W-1] != in1[W-1]);
      end
      OP_SUB: begin
        sc_res_c = diff_c;
        sc_ovf_c = (in1[W-1] != in2[W-1]) && (diff_c[W-1] != in1[W-1]);
      end
      OP_MFHI: sc_res_c = hi_q;
      OP_MFLO: sc_res_c = lo_q;
      OP_SLT:  sc_res_c = W'($signed(in1) < $signed(in2));
      OP_SLTU: sc_res_c = W'(in1 < in2);
      OP_SRA:  sc_res_c = $signed(in1) >>> shamt;
      OP_SRL:  sc_res_c = in1 >> shamt;
      OP_SLL:  sc_res_c = in1 << shamt;
      default: sc_res_c = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    out_d      = out;
    zf_d       = zeroFlag;
    ovf_d      = overflow;
    busy_d     = busy;
    done_d     = 1'b0;
    mdu_load_c = 1'b0;
    mdu_step_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (is_multicycle(aluControl)) begin
            mdu_load_c = 1'b1;
            cnt_d      = SHW'(W - 1);
            busy_d     = 1'b1;
            state_d    = ST_ITER;
          end else begin
            out_d  = sc_res_c;
            zf_d   = (sc_res_c == '0);
            ovf_d  = sc_ovf_c;
            done_d = 1'b1;
          end
        end
      end
      ST_ITER: begin
        mdu_step_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        hi_d    = mdu_hi_c;
        lo_d    = mdu_lo_c;
        out_d   = mdu_lo_c;
        zf_d    = (mdu_lo_c == '0);
        ovf_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out      <= '0;
      zeroFlag <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out      <= out_d;
      zeroFlag <= zf_d;
      overflow <= ovf_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed ops push expected results, a monitor
// pops and compares on every done pulse.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  aluControl;
  logic [31:0] in1, in2;
  logic [4:0]  shamt;
  logic [31:0] out;
  logic        zeroFlag, overflow, busy, done;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .aluControl (aluControl),
    .in1        (in1),
    .in2        (in2),
    .shamt      (shamt),
    .out        (out),
    .zeroFlag   (zeroFlag),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string       name;
    logic [31:0] o;
    logic        zf;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 out=%h expected no result", out);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".out"}, out, e.o);
          check({e.name, ".zf"}, 32'(zeroFlag), 32'(e.zf));
          check({e.name, ".ovf"}, 32'(overflow), 32'(e.ovf));
        end
      end
    end
  end

  // Called at a negedge; holds start for one rising edge and returns at the next negedge
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] eo, input logic ezf, input logic eovf);
    exp_t e;
    e.name = name; e.o = eo; e.zf = ezf; e.ovf = eovf;
    exp_q.push_back(e);
    start = 1'b1; aluControl = op; in1 = a; in2 = b; shamt = sh;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts remaining busy cycles, then expects the done pulse in the cycle busy falls
  task automatic wait_busy(input string name, input int exp_cycles);
    int c = 0;
    while (busy === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
    check({name, ".busy_cycles"}, 32'(c), 32'(exp_cycles));
    check({name, ".done_at_busy_fall"}, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; aluControl = 4'd0; in1 = '0; in2 = '0; shamt = '0;
    repeat (2) @(negedge clk);
    check("rst.out", out, 32'h0);
    check("rst.zf", 32'(zeroFlag), 32'd1);
    check("rst.ovf", 32'(overflow), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    reset = 1'b0;

    issue("mfhi_rst", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    issue("mflo_rst", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Back-to-back single-cycle ops
    issue("add_ovf",  OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1);
    issue("sub_eq",   OP_SUB,  32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0);
    issue("sub_ovf",  OP_SUB,  32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1);
    issue("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0);
    issue("sra",      OP_SRA,  32'h80000000, 32'h12345678, 5'd4, 32'hF8000000, 1'b0, 1'b0);
    issue("srl",      OP_SRL,  32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h08000000, 1'b0, 1'b0);
    issue("sll",      OP_SLL,  32'h00000001, 32'h0000000F, 5'd31, 32'h80000000, 1'b0, 1'b0);
    issue("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0);
    issue("slt",      OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0);
    issue("and",      OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, 1'b0);
    issue("or",       OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0);
    issue("xor",      OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 1'b0, 1'b0);
    issue("add_ovf2", OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1);

    // Multiply: -3 * 7 = -21
    issue("mult", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0);
    wait_busy("mult", 33);
    issue("mult.mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0);
    issue("mult.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);

    issue("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0);
    wait_busy("multu", 33);
    issue("multu.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0);

    issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0);
    wait_busy("divu", 33);
    issue("divu.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd2, 1'b0, 1'b0);

    issue("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0);
    wait_busy("div_neg", 33);
    issue("div_neg.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);

    issue("div_zero", OP_DIV, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    wait_busy("div_zero", 33);
    issue("div_zero.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd5, 1'b0, 1'b0);

    issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 1'b0);
    wait_busy("div_ovf", 33);
    issue("div_ovf.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Start while busy is ignored; out holds the previous result (0 from mfhi)
    issue("mult_hold", OP_MULTU, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; aluControl = OP_ADD; in1 = 32'd1; in2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("ignored_add.out", out, 32'h0);
    check("ignored_add.busy", 32'(busy), 32'd1);
    wait_busy("mult_hold", 28);
    issue("mult_hold.mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'd42, 1'b0, 1'b0);

    // Reset mid-operation aborts without a result and clears HI/LO
    issue("mult_abort", OP_MULTU, 32'hFFFFFFFF, 32'd3, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.out", out, 32'h0);
    issue("abort.mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    issue("abort.mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
